// File: rtl/bus_pkg.sv
// Shared bus-fabric definitions: master count limit, arbiter state type, master index type.
package bus_pkg;

    localparam int unsigned MASTER_NUM_MAX = 8;
    localparam int unsigned MASTER_IDX_W   = $clog2(MASTER_NUM_MAX);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    typedef logic [MASTER_IDX_W-1:0] master_idx_t;

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational round-robin picker: first requester scanning cyclically from i_last+1.
module bus_arb_rr_pick #(
    parameter int unsigned MASTER_NUM = 4,
    parameter int unsigned IDX_W      = $clog2(MASTER_NUM)
) (
    input  logic [MASTER_NUM-1:0] i_req,
    input  logic [IDX_W-1:0]      i_last,
    output logic [IDX_W-1:0]      o_winner,
    output logic                  o_valid
);

    // Scan i_last+1 .. i_last+MASTER_NUM (mod MASTER_NUM); the last owner is checked last.
    always_comb begin
        int unsigned v_idx;
        o_winner = '0;
        o_valid  = 1'b0;
        v_idx    = 0;
        for (int unsigned k = 1; k <= MASTER_NUM; k++) begin
            v_idx = 32'(i_last) + k;
            if (v_idx >= MASTER_NUM) begin
                v_idx = v_idx - MASTER_NUM;
            end
            if (!o_valid && i_req[IDX_W'(v_idx)]) begin
                o_winner = IDX_W'(v_idx);
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with registered one-hot grant and optional hold limit.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned MASTER_NUM = 4,
    parameter int unsigned MAX_HOLD   = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [MASTER_NUM-1:0]         m_req_i,
    output logic [MASTER_NUM-1:0]         m_grant_o,
    output logic [$clog2(MASTER_NUM)-1:0] owner_o,
    output logic                          busy_o
);

    localparam int unsigned           OWN_W    = $clog2(MASTER_NUM);
    localparam int unsigned           HOLD_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0]     HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [MASTER_NUM-1:0] ONE      = MASTER_NUM'(1);

    arb_state_t            r_state, w_state_nxt;
    logic [MASTER_NUM-1:0] r_grant, w_grant_nxt;
    logic [OWN_W-1:0]      r_owner, w_owner_nxt;
    logic [HOLD_W-1:0]     r_hold, w_hold_nxt, w_hold_now;
    logic                  r_busy, w_busy_nxt;
    logic [MASTER_NUM-1:0] w_owner_mask;
    logic [MASTER_NUM-1:0] w_pick_req;
    logic [OWN_W-1:0]      w_win;
    logic                  w_win_vld;

    assign w_owner_mask = ONE << r_owner;

    // While owned, the owner is masked out so only other masters can win the handover.
    always_comb begin
        w_pick_req = (r_state == OWNED) ? (m_req_i & ~w_owner_mask) : m_req_i;
    end

    // Owned-cycle count including the current cycle, saturating at the limit; r_hold
    // holds the count of completed cycles, so the limit trips after exactly MAX_HOLD cycles.
    always_comb begin
        w_hold_now = (r_hold == HOLD_MAX) ? r_hold : r_hold + 1'b1;
    end

    bus_arb_rr_pick #(
        .MASTER_NUM (MASTER_NUM)
    ) u_rr_pick (
        .i_req    (w_pick_req),
        .i_last   (r_owner),
        .o_winner (w_win),
        .o_valid  (w_win_vld)
    );

    // Next-state and next-output logic for the IDLE/OWNED arbiter.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_hold_nxt  = r_hold;
        w_busy_nxt  = r_busy;
        case (r_state)
            IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = OWNED;
                    w_grant_nxt = ONE << w_win;
                    w_owner_nxt = w_win;
                    w_hold_nxt  = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            OWNED: begin
                if (!m_req_i[r_owner]) begin
                    if (w_win_vld) begin
                        w_grant_nxt = ONE << w_win;
                        w_owner_nxt = w_win;
                        w_hold_nxt  = '0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                        w_hold_nxt  = '0;
                        w_busy_nxt  = 1'b0;
                    end
                end else if ((MAX_HOLD > 0) && (w_hold_now == HOLD_MAX) && w_win_vld) begin
                    w_grant_nxt = ONE << w_win;
                    w_owner_nxt = w_win;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt = w_hold_now;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_hold_nxt  = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops the grant immediately and favours master 0 next.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_owner <= OWN_W'(MASTER_NUM - 1);
            r_hold  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_hold  <= w_hold_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign m_grant_o = r_grant;
    assign owner_o   = r_owner;
    assign busy_o    = r_busy;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_bus_arbiter;

    localparam int unsigned N = 4;

    logic         clk_i   = 1'b0;
    logic         rst_n_i = 1'b0;
    logic [N-1:0] m_req_i = '0;

    logic [N-1:0] grant_h, grant_n;
    logic [1:0]   owner_h, owner_n;
    logic         busy_h, busy_n;

    bus_arbiter #(.MASTER_NUM(N), .MAX_HOLD(4)) u_dut_hold (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .m_req_i   (m_req_i),
        .m_grant_o (grant_h),
        .owner_o   (owner_h),
        .busy_o    (busy_h)
    );

    bus_arbiter #(.MASTER_NUM(N), .MAX_HOLD(0)) u_dut_nolim (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .m_req_i   (m_req_i),
        .m_grant_o (grant_n),
        .owner_o   (owner_n),
        .busy_o    (busy_n)
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model, index 0 = MAX_HOLD 4, index 1 = no limit.
    // mdl_hold counts cycles the current owner has held the grant, including the current one.
    int unsigned  mdl_limit[2] = '{4, 0};
    int unsigned  mdl_owner[2] = '{N - 1, N - 1};
    bit           mdl_busy[2]  = '{1'b0, 1'b0};
    int unsigned  mdl_hold[2]  = '{0, 0};
    logic [N-1:0] prev_g[2]    = '{'0, '0};

    function automatic int unsigned rr_pick(input logic [N-1:0] req, input int unsigned last);
        for (int unsigned k = 1; k <= N; k++) begin
            int unsigned idx;
            idx = (last + k) % N;
            if (req[idx]) return idx;
        end
        return last;
    endfunction

    task automatic mdl_step(input int i);
        logic [N-1:0] others;
        others = m_req_i & ~(N'(1) << mdl_owner[i]);
        if (!mdl_busy[i]) begin
            if (m_req_i != '0) begin
                mdl_owner[i] = rr_pick(m_req_i, mdl_owner[i]);
                mdl_busy[i]  = 1'b1;
                mdl_hold[i]  = 1;
            end
        end else if (!m_req_i[mdl_owner[i]]) begin
            if (others != '0) begin
                mdl_owner[i] = rr_pick(others, mdl_owner[i]);
                mdl_hold[i]  = 1;
            end else begin
                mdl_busy[i] = 1'b0;
            end
        end else if (mdl_limit[i] > 0 && mdl_hold[i] >= mdl_limit[i] && others != '0) begin
            mdl_owner[i] = rr_pick(others, mdl_owner[i]);
            mdl_hold[i]  = 1;
        end else begin
            mdl_hold[i]++;
        end
    endtask

    // Model advances on the same edges as the DUTs and resets asynchronously with them.
    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 2; i++) begin
                mdl_owner[i] = N - 1;
                mdl_busy[i]  = 1'b0;
                mdl_hold[i]  = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) mdl_step(i);
        end
    end

    task automatic check_dut(input string sfx, input int i, input logic [N-1:0] g,
                             input logic [1:0] o, input logic b);
        logic [N-1:0] exp_g;
        exp_g = mdl_busy[i] ? (N'(1) << mdl_owner[i]) : '0;
        check_eq({"grant_", sfx}, 32'(g), 32'(exp_g));
        check_eq({"owner_", sfx}, 32'(o), mdl_owner[i]);
        check_eq({"busy_", sfx}, 32'(b), 32'(mdl_busy[i]));
        check_eq({"onehot_", sfx}, 32'($countones(g) <= 1), 1);
        check_eq({"busy_or_", sfx}, 32'(b), 32'(|g));
        if (g != prev_g[i] && g != '0) begin
            check_eq({"req_at_grant_", sfx}, 32'(m_req_i[o]), 1);
        end
        prev_g[i] = g;
    endtask

    task automatic cycle();
        @(negedge clk_i);
        check_dut("h", 0, grant_h, owner_h, busy_h);
        check_dut("n", 1, grant_n, owner_n, busy_n);
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        m_req_i = '0;
        cycle();
        check_eq("rst_grant", 32'(grant_h), 0);
        check_eq("rst_owner", 32'(owner_h), N - 1);
        check_eq("rst_busy", 32'(busy_h), 0);
        rst_n_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned  exp_order[5] = '{0, 1, 2, 3, 0};
        int unsigned  held;
        bit           done;
        logic [N-1:0] r;

        // Single requester after reset.
        do_reset();
        m_req_i = 4'b0001;
        cycle();
        check_eq("single_grant", 32'(grant_h), 1);
        check_eq("single_owner", 32'(owner_h), 0);
        check_eq("single_busy", 32'(busy_h), 1);
        m_req_i = '0;
        cycle();
        check_eq("idle_owner_kept", 32'(owner_h), 0);
        check_eq("idle_busy", 32'(busy_h), 0);

        // Round-robin order with each owner releasing for one cycle.
        do_reset();
        m_req_i = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            cycle();
            check_eq("rr_order", 32'(owner_h), exp_order[j]);
            check_eq("rr_no_gap", 32'(busy_h), 1);
            m_req_i = 4'b1111 & ~(4'b0001 << exp_order[j]);
        end

        // Direct handover skips past master 0 to master 3.
        do_reset();
        m_req_i = 4'b0100;
        cycle();
        check_eq("ho_first", 32'(grant_h), 32'(4'b0100));
        m_req_i = 4'b1001;
        cycle();
        check_eq("ho_grant", 32'(grant_h), 32'(4'b1000));

        // Hold limit: master 0 keeps requesting while master 1 waits.
        do_reset();
        m_req_i = 4'b0001;
        cycle();
        m_req_i = 4'b0011;
        held = 1;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            cycle();
            if (grant_h == 4'b0001) held++;
            else done = 1'b1;
        end
        check_eq("hold_cycles", held, 4);
        check_eq("hold_next", 32'(grant_h), 32'(4'b0010));
        repeat (8) cycle();
        check_eq("nolim_kept", 32'(grant_n), 32'(4'b0001));

        // Reset in the middle of an ownership drops the grant before the next edge.
        do_reset();
        m_req_i = 4'b0100;
        cycle();
        check_eq("pre_rst_grant", 32'(grant_h), 32'(4'b0100));
        #2 rst_n_i = 1'b0;
        #1;
        check_eq("async_rst_grant", 32'(grant_h), 0);
        check_eq("async_rst_busy", 32'(busy_h), 0);
        check_eq("async_rst_owner", 32'(owner_h), N - 1);
        cycle();
        rst_n_i = 1'b1;
        cycle();
        check_eq("post_rst_grant", 32'(grant_h), 32'(4'b0100));
        check_eq("post_rst_owner", 32'(owner_h), 2);

        // Random traffic with sticky requests so hold limits are actually reached.
        r = '0;
        for (int it = 0; it < 600; it++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            end
            if ($urandom_range(31) == 0) r = '0;
            m_req_i = r;
            if ($urandom_range(79) == 0) begin
                rst_n_i = 1'b0;
                cycle();
                rst_n_i = 1'b1;
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
